// File: rtl/cache_req_arbiter.sv
// Round-robin front-end for a shared read-only cache and backing memory.
// Each granted request runs lookup, optional line fetch and fill, re-lookup, then respond.
module cache_req_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OFF_W  = 6,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              done0,
    output logic              done1,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic              c_lookup,
    output logic [ADDR_W-1:0] c_addr,
    input  logic              c_hit,
    input  logic [31:0]       c_rdata,
    output logic              c_fill,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    input  logic              m_ack,
    output logic [CNT_W-1:0]  miss_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StCheck,
        StMreq,
        StFill,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic              refilled_q, refilled_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic              gnt;

    // Next-state logic: arbitration, transaction sequencing and bookkeeping.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        refilled_d = refilled_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        miss_cnt_d = miss_cnt_q;
        // Contention goes to the port that was not served last.
        gnt        = (req0 && req1) ? ~last_gnt_q : req1;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    addr_d     = gnt ? addr1 : addr0;
                    owner_d    = gnt;
                    refilled_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = StLookup;
                end
            end
            StLookup: state_d = StCheck;
            StCheck: begin
                if (c_hit) begin
                    rdata_d = c_rdata;
                    state_d = StResp;
                end else if (!refilled_q) begin
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    state_d = StMreq;
                end else begin
                    // Miss after our own fill: report rather than refetch forever.
                    rdata_d = c_rdata;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StMreq: begin
                if (m_ack) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                refilled_d = 1'b1;
                state_d    = StLookup;
            end
            StResp: begin
                last_gnt_d = owner_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            refilled_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            refilled_q <= refilled_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Output decode: strobes and levels are pure functions of the current state.
    always_comb begin
        done0    = 1'b0;
        done1    = 1'b0;
        err      = 1'b0;
        c_lookup = 1'b0;
        c_fill   = 1'b0;
        m_req    = 1'b0;
        busy     = (state_q != StIdle);
        unique case (state_q)
            StLookup: c_lookup = 1'b1;
            StMreq:   m_req    = 1'b1;
            StFill:   c_fill   = 1'b1;
            StResp: begin
                done0 = ~owner_q;
                done1 = owner_q;
                err   = err_q;
            end
            default: ;
        endcase
    end

    assign rdata    = rdata_q;
    assign c_addr   = addr_q;
    assign m_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a small cache and memory responder.
module tb_cache_req_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned OW = 6;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          done0, done1, err, busy, c_lookup, c_fill, m_req;
    logic [31:0]   rdata;
    logic [AW-1:0] c_addr, m_addr;
    logic          c_hit;
    logic [31:0]   c_rdata;
    logic          m_ack = 1'b0;
    logic [CW-1:0] miss_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fills = 0;
    int mreq_starts = 0;
    int fill_base = 0;
    int ack_wait = 0;
    int mcnt = 0;
    logic        m_req_prev = 1'b0;
    logic [31:0] maddr_seen = '0;
    logic        hit_before = 1'b1, hit_after = 1'b1;
    logic [31:0] data_before = '0, data_after = '0;

    cache_req_arbiter #(.ADDR_W(AW), .OFF_W(OW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .done0(done0), .done1(done1), .rdata(rdata), .err(err), .busy(busy),
        .c_lookup(c_lookup), .c_addr(c_addr), .c_hit(c_hit), .c_rdata(c_rdata),
        .c_fill(c_fill), .m_req(m_req), .m_addr(m_addr), .m_ack(m_ack),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Cache answers differently once this transaction has filled a line.
    assign c_hit   = (fills > fill_base) ? hit_after : hit_before;
    assign c_rdata = (fills > fill_base) ? data_after : data_before;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        m_req_prev <= m_req;
        if (m_req && !m_req_prev) mreq_starts <= mreq_starts + 1;
        if (m_req) maddr_seen <= m_addr;
        if (c_fill) fills <= fills + 1;
    end

    // Memory acks on the (ack_wait+1)-th cycle of m_req.
    always @(negedge clk) begin
        if (m_req) begin
            m_ack <= (mcnt == ack_wait);
            mcnt  <= mcnt + 1;
        end else begin
            m_ack <= 1'b0;
            mcnt  <= 0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one request from an idle DUT; off counts cycles after the grant edge.
    task automatic run_txn(input int port, input logic [31:0] addr, output bit got,
                           output int which, output int off, output logic errv,
                           output logic [31:0] data, output logic lk,
                           output logic [31:0] lk_addr);
        int g;
        got = 1'b0; which = -1; off = -1; errv = 1'bx; data = 'x;
        @(negedge clk);
        if (port == 0) begin req0 = 1'b1; addr0 = addr; end
        else begin req1 = 1'b1; addr1 = addr; end
        @(posedge clk);
        @(negedge clk);
        g = cyc;
        lk = c_lookup;
        lk_addr = c_addr;
        for (int i = 0; i < 200 && !got; i++) begin
            if (done0 || done1) begin
                got = 1'b1;
                which = done1 ? 1 : 0;
                errv = err;
                data = rdata;
                off = cyc - g + 1;
            end else begin
                @(negedge clk);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({busy, done0, done1, err, c_lookup, c_fill, m_req} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, done0, done1, err, c_lookup, c_fill, m_req});
        end
        n_cmp++;
        if (rdata !== 32'h0 || miss_cnt !== 4'd0 || c_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: rdata %h miss %0d c_addr %h want all 0",
                     rdata, miss_cnt, c_addr);
        end
    endtask

    task automatic test_hit();
        bit got; int which, off; logic errv, lk; logic [31:0] data, lka;
        hit_before = 1'b1; data_before = 32'hDEAD_BEEF; fill_base = fills;
        run_txn(0, 32'h0000_0104, got, which, off, errv, data, lk, lka);
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL hit_timeout: got none want done0"); end
        n_cmp++;
        if (lk !== 1'b1 || lka !== 32'h104) begin
            n_bad++; $display("FAIL hit_lookup: got %b/%h want 1/00000104", lk, lka);
        end
        n_cmp++;
        if (which !== 0 || off !== 3) begin
            n_bad++; $display("FAIL hit_latency: got port %0d off %0d want 0/3", which, off);
        end
        n_cmp++;
        if (data !== 32'hDEAD_BEEF || errv !== 1'b0 || miss_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL hit_data: got %h err %b miss %0d want deadbeef/0/0",
                     data, errv, miss_cnt);
        end
    endtask

    task automatic test_miss();
        bit got; int which, off, f0; logic errv, lk; logic [31:0] data, lka;
        hit_before = 1'b0; hit_after = 1'b1; data_after = 32'h1111_2222; ack_wait = 4;
        fill_base = fills; f0 = fills;
        run_txn(1, 32'h0000_1234, got, which, off, errv, data, lk, lka);
        n_cmp++;
        if (!got || which !== 1 || off !== 11) begin
            n_bad++;
            $display("FAIL miss_latency: got %b port %0d off %0d want 1/1/11", got, which, off);
        end
        n_cmp++;
        if (maddr_seen !== 32'h0000_1200) begin
            n_bad++; $display("FAIL miss_maddr: got %h want 00001200", maddr_seen);
        end
        n_cmp++;
        if (fills - f0 !== 1) begin
            n_bad++; $display("FAIL miss_fill: got %0d want 1", fills - f0);
        end
        n_cmp++;
        if (data !== 32'h1111_2222 || errv !== 1'b0 || miss_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL miss_data: got %h err %b miss %0d want 11112222/0/1",
                     data, errv, miss_cnt);
        end
    endtask

    task automatic test_err();
        bit got; int which, off, s0; logic errv, lk; logic [31:0] data, lka;
        hit_before = 1'b0; hit_after = 1'b0; data_before = 32'hCAFE_0001;
        data_after = 32'hCAFE_0001; ack_wait = 1; fill_base = fills; s0 = mreq_starts;
        run_txn(0, 32'h0000_0040, got, which, off, errv, data, lk, lka);
        n_cmp++;
        if (!got || which !== 0 || off !== 8 || errv !== 1'b1) begin
            n_bad++;
            $display("FAIL err_resp: got %b port %0d off %0d err %b want 1/0/8/1",
                     got, which, off, errv);
        end
        n_cmp++;
        if (mreq_starts - s0 !== 1 || miss_cnt !== 4'd2 || data !== 32'hCAFE_0001) begin
            n_bad++;
            $display("FAIL err_count: mreqs %0d miss %0d data %h want 1/2/cafe0001",
                     mreq_starts - s0, miss_cnt, data);
        end
    endtask

    task automatic test_reset_mid();
        bit seen; bit got; int first;
        hit_before = 1'b0; hit_after = 1'b1; ack_wait = 1000; fill_base = fills;
        @(negedge clk);
        req0 = 1'b1; addr0 = 32'h0000_0800;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_req;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL rstmid_mreq: got no m_req want m_req"); end
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        n_cmp++;
        if (m_req !== 1'b0 || busy !== 1'b0 || done0 !== 1'b0 || miss_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL rstmid_async: m_req %b busy %b done0 %b miss %0d want 0/0/0/0",
                     m_req, busy, done0, miss_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hit_before = 1'b1; ack_wait = 0;
        // Port 0 was served last before reset; reset must restore port 0 priority.
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h10; addr1 = 32'h20;
        got = 1'b0; first = -1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (done0 || done1) begin got = 1'b1; first = done1 ? 1 : 0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_cmp++;
        if (first !== 0) begin
            n_bad++; $display("FAIL rstmid_first: got port %0d want 0", first);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int order[4]; int n; bit re0, re1;
        int exp_order[4];
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
        do_reset();
        hit_before = 1'b1; fill_base = fills;
        n = 0; re0 = 1'b0; re1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h100; addr1 = 32'h200;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk);
            if (re0) begin req0 = 1'b1; re0 = 1'b0; end
            if (re1) begin req1 = 1'b1; re1 = 1'b0; end
            if (done0) begin order[n] = 0; n++; req0 = 1'b0; re0 = 1'b1; end
            else if (done1) begin order[n] = 1; n++; req1 = 1'b0; re1 = 1'b1; end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_cmp++;
        if (n !== 4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", n); end
        for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (order[k] !== exp_order[k]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        bit got; int which, off; logic errv, lk; logic [31:0] data, lka;
        do_reset();
        hit_before = 1'b0; hit_after = 1'b1; ack_wait = 0;
        for (int i = 0; i < 15; i++) begin
            fill_base = fills;
            run_txn(0, 32'h4000 + 32'(i * 64), got, which, off, errv, data, lk, lka);
        end
        n_cmp++;
        if (miss_cnt !== 4'd15) begin
            n_bad++; $display("FAIL sat_15: got %0d want 15", miss_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            fill_base = fills;
            run_txn(1, 32'h8000 + 32'(i * 64), got, which, off, errv, data, lk, lka);
        end
        n_cmp++;
        if (miss_cnt !== 4'd15) begin
            n_bad++; $display("FAIL sat_hold: got %0d want 15", miss_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_err();
        test_reset_mid();
        test_round_robin();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
